// File: rtl/pc_ir_unit_if.sv
// pc_ir_unit_if: controller/datapath bus for the PC, IR and MDR stage
interface pc_ir_unit_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              pc_write;
    logic              pc_write_cond;
    logic              beq;
    logic [1:0]        pc_src;
    logic              ir_write;
    logic              iord;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] mdr;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [CNT_W-1:0]  retired_cnt;

    modport master (
        output pc_write, pc_write_cond, beq, pc_src, ir_write, iord,
               alu_result, alu_out, alu_zero, mem_rdata,
        input  mem_addr, pc, ir, mdr, opcode, rs, rt, rd, imm, retired_cnt
    );

    modport slave (
        input  pc_write, pc_write_cond, beq, pc_src, ir_write, iord,
               alu_result, alu_out, alu_zero, mem_rdata,
        output mem_addr, pc, ir, mdr, opcode, rs, rt, rd, imm, retired_cnt
    );
endinterface

// File: rtl/pc_ir_unit.sv
// pc_ir_unit: program counter, instruction register and memory data register of the multicycle CPU
module pc_ir_unit #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input logic         clock,
    input logic         reset,
    pc_ir_unit_if.slave bus
);
    logic [DATA_W-1:0] pcReg;
    logic [DATA_W-1:0] irReg;
    logic [DATA_W-1:0] mdrReg;
    logic [CNT_W-1:0]  cntReg;
    logic              pcEn;
    logic              retire;
    logic [DATA_W-1:0] pcNext;

    // PC load decision and next-PC selection; pc_src 11 holds even when enabled
    always_comb begin
        pcEn   = bus.pc_write | (bus.pc_write_cond & (bus.alu_zero ~^ bus.beq));
        retire = bus.ir_write & (bus.mem_rdata[DATA_W-1 -: 6] != 6'd0);
        pcNext = bus.pc_src == 2'b00 ? bus.alu_result :
                 bus.pc_src == 2'b01 ? bus.alu_out :
                 bus.pc_src == 2'b10 ? {pcReg[DATA_W-1:26], irReg[25:0]} : pcReg;
    end

    // Register updates; active-low reset aborts everything in flight
    always_ff @(posedge clock) begin
        if (!reset) begin
            pcReg  <= RESET_PC;
            irReg  <= '0;
            mdrReg <= '0;
            cntReg <= '0;
        end else begin
            if (pcEn) pcReg <= pcNext;
            if (bus.ir_write) irReg <= bus.mem_rdata;
            mdrReg <= bus.mem_rdata;
            if (retire) cntReg <= cntReg + CNT_W'(1);
        end
    end

    // Memory address mux, opcode bypass for the fetch state, and IR field decode
    always_comb begin
        bus.mem_addr    = bus.iord ? bus.alu_out : pcReg;
        bus.opcode      = bus.ir_write ? bus.mem_rdata[DATA_W-1 -: 6] : irReg[DATA_W-1 -: 6];
        bus.pc          = pcReg;
        bus.ir          = irReg;
        bus.mdr         = mdrReg;
        bus.rs          = irReg[25:21];
        bus.rt          = irReg[20:16];
        bus.rd          = irReg[15:11];
        bus.imm         = irReg[15:0];
        bus.retired_cnt = cntReg;
    end
endmodule

// File: tb/tb_pc_ir_unit.sv
// tb_pc_ir_unit: directed and randomized checks of pc_ir_unit against a behavioural model
module tb_pc_ir_unit;
    localparam int DW = 32;
    localparam int CW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mPc, mIr, mMdr;
    logic [CW-1:0] mCnt;

    pc_ir_unit_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    pc_ir_unit #(.DATA_W(DW), .RESET_PC(32'h0), .CNT_W(CW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.pc_write = 0; bus.pc_write_cond = 0; bus.beq = 0; bus.pc_src = 2'b00;
        bus.ir_write = 0; bus.iord = 0; bus.alu_result = '0; bus.alu_out = '0;
        bus.alu_zero = 0; bus.mem_rdata = '0;
    endtask

    // One clock: check combinational outputs, predict the edge, check registered state
    task automatic step();
        logic [DW-1:0] nPc, nIr, nMdr;
        logic [CW-1:0] nCnt;
        logic taken;
        #1;
        chk("mem_addr", bus.mem_addr, bus.iord ? bus.alu_out : mPc);
        chk("opcode", 32'(bus.opcode), 32'(bus.ir_write ? bus.mem_rdata[31:26] : mIr[31:26]));
        if (!reset) begin
            nPc = '0; nIr = '0; nMdr = '0; nCnt = '0;
        end else begin
            taken = bus.pc_write || (bus.pc_write_cond && (bus.alu_zero == bus.beq));
            nPc = mPc;
            if (taken) begin
                case (bus.pc_src)
                    2'd0: nPc = bus.alu_result;
                    2'd1: nPc = bus.alu_out;
                    2'd2: nPc = {mPc[31:26], mIr[25:0]};
                    default: nPc = mPc;
                endcase
            end
            nIr  = bus.ir_write ? bus.mem_rdata : mIr;
            nMdr = bus.mem_rdata;
            nCnt = (bus.ir_write && bus.mem_rdata[31:26] != 6'd0) ? CW'((int'(mCnt) + 1) % 16) : mCnt;
        end
        @(posedge clock);
        #1;
        mPc = nPc; mIr = nIr; mMdr = nMdr; mCnt = nCnt;
        chk("pc", bus.pc, mPc);
        chk("ir", bus.ir, mIr);
        chk("mdr", bus.mdr, mMdr);
        chk("retired_cnt", 32'(bus.retired_cnt), 32'(mCnt));
        chk("rs", 32'(bus.rs), 32'(mIr[25:21]));
        chk("rt", 32'(bus.rt), 32'(mIr[20:16]));
        chk("rd", 32'(bus.rd), 32'(mIr[15:11]));
        chk("imm", 32'(bus.imm), 32'(mIr[15:0]));
    endtask

    initial begin
        idle();
        reset = 0;
        repeat (2) @(posedge clock);
        #1;
        mPc = '0; mIr = '0; mMdr = '0; mCnt = '0;
        reset = 1;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_ir", bus.ir, 32'h0);
        chk("rst_mdr", bus.mdr, 32'h0);
        chk("rst_cnt", 32'(bus.retired_cnt), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);

        bus.ir_write = 1; bus.pc_write = 1; bus.alu_result = 32'h1; bus.mem_rdata = 32'h8C22_0005;
        #1 chk("fetch_opcode", 32'(bus.opcode), 32'h23);
        step();
        chk("fetch_pc", bus.pc, 32'h1);
        chk("fetch_rs", 32'(bus.rs), 32'd1);
        chk("fetch_rt", 32'(bus.rt), 32'd2);
        chk("fetch_imm", 32'(bus.imm), 32'd5);
        chk("fetch_cnt", 32'(bus.retired_cnt), 32'd1);

        idle(); bus.pc_write_cond = 1; bus.beq = 1; bus.pc_src = 2'b01;
        bus.alu_out = 32'h40; bus.alu_zero = 1; step();
        chk("beq_taken", bus.pc, 32'h40);
        bus.alu_out = 32'h80; bus.alu_zero = 0; step();
        chk("beq_not_taken", bus.pc, 32'h40);
        bus.beq = 0; bus.alu_zero = 0; step();
        chk("bne_taken", bus.pc, 32'h80);
        bus.alu_out = 32'hC0; bus.alu_zero = 1; step();
        chk("bne_not_taken", bus.pc, 32'h80);
        bus.pc_write = 1; bus.alu_zero = 0; bus.beq = 1; step();
        chk("pc_write_wins", bus.pc, 32'hC0);
        bus.pc_src = 2'b11; bus.alu_zero = 1; step();
        chk("pc_src_hold", bus.pc, 32'hC0);

        idle(); bus.pc_write = 1; bus.alu_result = 32'hF000_0010;
        bus.ir_write = 1; bus.mem_rdata = 32'h0000_0123; step();
        idle(); bus.pc_write = 1; bus.pc_src = 2'b10; step();
        chk("jump_pc", bus.pc, 32'hF000_0123);

        idle(); bus.iord = 1; bus.alu_out = 32'h20; bus.mem_rdata = 32'hDEAD_BEEF;
        #1 chk("load_addr", bus.mem_addr, 32'h20);
        step();
        chk("load_mdr", bus.mdr, 32'hDEAD_BEEF);
        bus.iord = 0; #1 chk("addr_pc", bus.mem_addr, 32'hF000_0123);

        idle(); bus.ir_write = 1; step();
        chk("noop_cnt", 32'(bus.retired_cnt), 32'd1);

        reset = 0; idle(); step(); reset = 1;
        for (int i = 0; i < 16; i++) begin
            idle(); bus.ir_write = 1; bus.mem_rdata = 32'h0400_0000 | 32'(i); step();
        end
        chk("cnt_wrap", 32'(bus.retired_cnt), 32'd0);

        idle(); reset = 0; bus.pc_write = 1; bus.alu_result = 32'h1234; step(); reset = 1;
        chk("reset_over_write", bus.pc, 32'h0);

        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(0, 24) != 0);
            bus.pc_write = 1'($urandom_range(0, 3) == 0);
            bus.pc_write_cond = 1'($urandom);
            bus.beq = 1'($urandom);
            bus.pc_src = 2'($urandom);
            bus.ir_write = 1'($urandom);
            bus.iord = 1'($urandom);
            bus.alu_result = $urandom;
            bus.alu_out = $urandom;
            bus.alu_zero = 1'($urandom);
            bus.mem_rdata = $urandom;
            if ($urandom_range(0, 3) == 0) bus.mem_rdata[31:26] = 6'd0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
